// File: rtl/quad_pkg.sv
// Shared types and constants for the quad scanline sequencer.
// Coordinates are unsigned 10-bit screen values; vertex [i][0] is x and [i][1] is y.
package quad_pkg;

  localparam int COORD_W       = 10;
  localparam int V_RES_DEFAULT = 480;

  typedef logic [COORD_W-1:0] coord_t;
  typedef coord_t [1:0]       vec2_t;   // [0] = x, [1] = y
  typedef vec2_t  [3:0]       quad_t;   // four vertices, counter-clockwise

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SCAN,
    EMIT
  } state_e;

  function automatic coord_t umin(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t umax(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/quad_scan_sequencer_if.sv
// Bundles the quad input, rasterizer and row output handshakes of the sequencer.
// slave is the sequencer's view; master is the surrounding system's view.
interface quad_scan_sequencer_if
  import quad_pkg::*;
#(
  parameter int warp_width = 320
);

  logic                  quad_valid;
  logic                  quad_ready;
  quad_t                 quad_vertices;

  quad_t                 rast_vertices;
  coord_t                rast_drawY;
  logic [warp_width-1:0] rast_isInside;

  logic                  row_valid;
  logic                  row_ready;
  coord_t                row_y;
  logic [warp_width-1:0] row_mask;
  logic                  row_last;
  logic                  quad_done;

  modport slave (
    input  quad_valid, quad_vertices, rast_isInside, row_ready,
    output quad_ready, rast_vertices, rast_drawY,
           row_valid, row_y, row_mask, row_last, quad_done
  );

  modport master (
    output quad_valid, quad_vertices, rast_isInside, row_ready,
    input  quad_ready, rast_vertices, rast_drawY,
           row_valid, row_y, row_mask, row_last, quad_done
  );

endinterface

// File: rtl/quad_ybounds.sv
// Vertical extent of a quad: min/max of the four y values, with the bottom
// clipped to the last screen row. empty flags a quad lying fully below the screen.
module quad_ybounds
  import quad_pkg::*;
#(
  parameter int V_RES = V_RES_DEFAULT
) (
  input  quad_t  quad,
  output coord_t ymin,
  output coord_t ymax_c,
  output logic   empty
);

  localparam coord_t YCLIP = coord_t'(V_RES - 1);

  coord_t ymax;

  always_comb begin
    ymin   = umin(umin(quad[0][1], quad[1][1]), umin(quad[2][1], quad[3][1]));
    ymax   = umax(umax(quad[0][1], quad[1][1]), umax(quad[2][1], quad[3][1]));
    ymax_c = (ymax > YCLIP) ? YCLIP : ymax;
    empty  = (ymin > ymax_c);
  end

endmodule

// File: rtl/quad_scan_sequencer.sv
// Walks an accepted quad one scanline at a time through a combinational
// rasterizer and streams the non-empty {y, mask} rows downstream.
module quad_scan_sequencer
  import quad_pkg::*;
#(
  parameter int warp_width = 320,
  parameter int V_RES      = V_RES_DEFAULT,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  quad_scan_sequencer_if.slave bus
);

  state_e                state_q,     state_d;
  quad_t                 verts_q,     verts_d;
  coord_t                drawy_q,     drawy_d;
  logic                  row_valid_q, row_valid_d;
  coord_t                row_y_q,     row_y_d;
  logic [warp_width-1:0] row_mask_q,  row_mask_d;
  logic                  row_last_q,  row_last_d;
  logic                  quad_done_q, quad_done_d;
  logic                  quad_ready_q, quad_ready_d;

  coord_t ymin;
  coord_t ymax_c;
  logic   bounds_empty;
  logic   scan_last;
  logic   mask_zero;

  quad_ybounds #(
    .V_RES (V_RES)
  ) u_ybounds (
    .quad   (verts_q),
    .ymin   (ymin),
    .ymax_c (ymax_c),
    .empty  (bounds_empty)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here is what infers a latch.
    state_d     = state_q;
    verts_d     = verts_q;
    drawy_d     = drawy_q;
    row_valid_d = row_valid_q;
    row_y_d     = row_y_q;
    row_mask_d  = row_mask_q;
    row_last_d  = row_last_q;
    quad_done_d = 1'b0;

    scan_last = (drawy_q == ymax_c);
    mask_zero = (bus.rast_isInside == '0);

    unique case (state_q)
      IDLE: begin
        if (bus.quad_valid && quad_ready_q) begin
          verts_d = bus.quad_vertices;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (bounds_empty) begin
          quad_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          drawy_d = ymin;
          state_d = SCAN;
        end
      end

      SCAN: begin
        // The rasterizer is combinational, so its mask for drawy_q is valid now.
        if (SKIP_EMPTY && mask_zero) begin
          if (scan_last) begin
            quad_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            drawy_d = drawy_q + coord_t'(1);
          end
        end else begin
          row_y_d     = drawy_q;
          row_mask_d  = bus.rast_isInside;
          row_last_d  = scan_last;
          row_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end

      EMIT: begin
        if (bus.row_ready) begin
          row_valid_d = 1'b0;
          row_last_d  = 1'b0;
          if (row_last_q) begin
            quad_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            drawy_d = drawy_q + coord_t'(1);
            state_d = SCAN;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Ready only after a full cycle in IDLE, so never alongside quad_done.
    quad_ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge Clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (Reset) begin
      state_q      <= IDLE;
      verts_q      <= '0;
      drawy_q      <= '0;
      row_valid_q  <= 1'b0;
      row_y_q      <= '0;
      row_mask_q   <= '0;
      row_last_q   <= 1'b0;
      quad_done_q  <= 1'b0;
      quad_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      verts_q      <= verts_d;
      drawy_q      <= drawy_d;
      row_valid_q  <= row_valid_d;
      row_y_q      <= row_y_d;
      row_mask_q   <= row_mask_d;
      row_last_q   <= row_last_d;
      quad_done_q  <= quad_done_d;
      quad_ready_q <= quad_ready_d;
    end
  end

  assign bus.quad_ready    = quad_ready_q;
  assign bus.rast_vertices = verts_q;
  assign bus.rast_drawY    = drawy_q;
  assign bus.row_valid     = row_valid_q;
  assign bus.row_y         = row_y_q;
  assign bus.row_mask      = row_mask_q;
  assign bus.row_last      = row_last_q;
  assign bus.quad_done     = quad_done_q;

endmodule

// File: tb/tb_quad_scan_sequencer.sv
// Scoreboard bench for quad_scan_sequencer with a behavioural edge-function
// rasterizer standing in for the real one.
module tb_quad_scan_sequencer;
  import quad_pkg::*;

  localparam int W    = 320;
  localparam int VRES = 480;

  typedef struct {
    int            y;
    logic [W-1:0]  mask;
    bit            last;
  } row_t;

  logic clk;
  logic reset;

  quad_scan_sequencer_if #(.warp_width(W)) bus ();

  quad_scan_sequencer #(
    .warp_width (W),
    .V_RES      (VRES),
    .SKIP_EMPTY (1'b1)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel inside when it lies on the inner side (or on) every directed edge.
  function automatic logic [W-1:0] raster_row(input quad_t q, input int y);
    logic [W-1:0] m;
    m = '0;
    for (int x = 0; x < W; x++) begin
      bit hit;
      hit = 1'b1;
      for (int i = 0; i < 4; i++) begin
        int x0, y0, x1, y1;
        x0 = int'(q[i][0]);
        y0 = int'(q[i][1]);
        x1 = int'(q[(i + 1) % 4][0]);
        y1 = int'(q[(i + 1) % 4][1]);
        if ((x1 - x0) * (y - y0) - (y1 - y0) * (x - x0) > 0) hit = 1'b0;
      end
      m[x] = hit;
    end
    return m;
  endfunction

  always_comb bus.rast_isInside = raster_row(bus.rast_vertices, int'(bus.rast_drawY));

  function automatic quad_t mk_quad(input int x0, input int y0, input int x1, input int y1,
                                    input int x2, input int y2, input int x3, input int y3);
    quad_t q;
    q[0][0] = coord_t'(x0); q[0][1] = coord_t'(y0);
    q[1][0] = coord_t'(x1); q[1][1] = coord_t'(y1);
    q[2][0] = coord_t'(x2); q[2][1] = coord_t'(y2);
    q[3][0] = coord_t'(x3); q[3][1] = coord_t'(y3);
    return q;
  endfunction

  int   n_cmp = 0;
  int   n_err = 0;
  row_t exp_q[$];
  int   exp_done = 0;
  int   got_done = 0;
  int   rows_hs = 0;
  int   rowlast_cnt = 0;
  int   last_hs_y = -1;
  int   drawy_viol = 0;
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;
  bit   stall_armed = 1'b0;
  int   stall_y = 0;
  int   stall_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: every row from the top of the quad to its clipped bottom,
  // keeping only rows where the rasterizer reports at least one pixel.
  task automatic model_push(input quad_t q);
    int ymin, ymax, ymax_c;
    ymin = 1023;
    ymax = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(q[i][1]) < ymin) ymin = int'(q[i][1]);
      if (int'(q[i][1]) > ymax) ymax = int'(q[i][1]);
    end
    ymax_c = (ymax > VRES - 1) ? VRES - 1 : ymax;
    for (int y = ymin; y <= ymax_c; y++) begin
      row_t r;
      r.y    = y;
      r.mask = raster_row(q, y);
      r.last = (y == ymax_c);
      if (r.mask != '0) exp_q.push_back(r);
    end
    exp_done++;
  endtask

  // Downstream ready: held high, randomised, or stalled 5 cycles on a chosen row.
  initial begin
    bus.row_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_armed && bus.row_valid && int'(bus.row_y) == stall_y) begin
        stall_cnt   = 5;
        stall_armed = 1'b0;
      end
      if (stall_cnt > 0) begin
        bus.row_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        bus.row_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.row_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every row handshake and checks that a
  // stalled row stays frozen.
  initial begin
    bit           hold_v, done_due;
    int           hold_y;
    logic [W-1:0] hold_mask;
    logic         hold_last;
    hold_v = 1'b0;
    done_due = 1'b0;
    hold_y = 0;
    hold_mask = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        hold_v   = 1'b0;
        done_due = 1'b0;
      end else begin
        if (done_due) check("quad_done_after_last_row", bus.quad_done, 1);
        done_due = 1'b0;
        if (hold_v) begin
          check("stall_row_valid", bus.row_valid, 1);
          check("stall_row_y", bus.row_y, hold_y);
          check("stall_row_mask", bus.row_mask, hold_mask);
          check("stall_row_last", bus.row_last, hold_last);
          check("stall_drawY", bus.rast_drawY, hold_y);
        end
        if (bus.quad_done) got_done++;
        if (int'(bus.rast_drawY) >= VRES) drawy_viol++;
        if (bus.row_valid && bus.row_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_row_y", bus.row_y, 1023);
          end else begin
            row_t r;
            r = exp_q.pop_front();
            check("row_y", bus.row_y, r.y);
            check("row_mask", bus.row_mask, r.mask);
            check("row_last", bus.row_last, r.last);
          end
          rows_hs++;
          if (bus.row_last) rowlast_cnt++;
          last_hs_y = int'(bus.row_y);
          done_due  = bus.row_last;
          hold_v    = 1'b0;
        end else if (bus.row_valid) begin
          hold_v    = 1'b1;
          hold_y    = int'(bus.row_y);
          hold_mask = bus.row_mask;
          hold_last = bus.row_last;
        end else begin
          hold_v = 1'b0;
        end
      end
    end
  end

  task automatic issue_quad(input quad_t q);
    int n;
    n = 0;
    rows_hs     = 0;
    rowlast_cnt = 0;
    last_hs_y   = -1;
    model_push(q);
    @(posedge clk);
    #1;
    bus.quad_vertices = q;
    bus.quad_valid    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.quad_ready && n < 100);
    check("quad_accepted", bus.quad_ready, 1);
    @(posedge clk);
    #1;
    bus.quad_valid    = 1'b0;
    bus.quad_vertices = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (got_done != exp_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("quad_done_seen", got_done, exp_done);
    check("rows_outstanding", exp_q.size(), 0);
    @(negedge clk);
    check("quad_ready_after_done", bus.quad_ready, 1);
  endtask

  initial begin
    quad_t sq;
    int    n;
    bit    any_valid, any_done;
    sq = mk_quad(100, 100, 100, 102, 102, 102, 102, 100);

    reset             = 1'b1;
    bus.quad_valid    = 1'b0;
    bus.quad_vertices = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_quad_ready", bus.quad_ready, 0);
    check("rst_row_valid", bus.row_valid, 0);
    check("rst_row_last", bus.row_last, 0);
    check("rst_quad_done", bus.quad_done, 0);
    check("rst_row_y", bus.row_y, 0);
    check("rst_row_mask", bus.row_mask, 0);
    check("rst_drawY", bus.rast_drawY, 0);
    check("rst_rast_vertices", bus.rast_vertices, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_quad_ready", bus.quad_ready, 1);
    mon_en = 1'b1;

    // Axis square, ready held high.
    issue_quad(sq);
    wait_done();
    check("square_rows", rows_hs, 3);
    check("square_last_y", last_hs_y, 102);
    check("square_row_last_count", rowlast_cnt, 1);

    // Same square with a 5-cycle stall on y=101.
    stall_y     = 101;
    stall_armed = 1'b1;
    issue_quad(sq);
    wait_done();
    check("stall_rows", rows_hs, 3);

    // Crosses the bottom of the screen.
    drawy_viol = 0;
    issue_quad(mk_quad(100, 470, 100, 490, 110, 490, 110, 470));
    wait_done();
    check("clip_last_y", last_hs_y, 479);
    check("clip_rows", rows_hs, 10);
    check("clip_drawY_in_range", drawy_viol, 0);

    // Entirely below the screen.
    issue_quad(mk_quad(10, 500, 10, 500, 20, 500, 20, 500));
    wait_done();
    check("offscreen_rows", rows_hs, 0);

    // Thin wedge visible only on y=202 within the row width.
    issue_quad(mk_quad(318, 202, 340, 204, 340, 204, 340, 200));
    wait_done();
    check("thin_rows", rows_hs, 1);
    check("thin_row_y", last_hs_y, 202);
    check("thin_row_last_count", rowlast_cnt, 0);

    // Reset while a row is stalled in EMIT.
    stall_y     = 101;
    stall_armed = 1'b1;
    issue_quad(sq);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.row_valid && !bus.row_ready) && n < 200);
    check("reach_emit_stall", bus.row_valid && !bus.row_ready, 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("abort_row_valid", bus.row_valid, 0);
    check("abort_quad_done", bus.quad_done, 0);
    check("abort_quad_ready", bus.quad_ready, 0);
    check("abort_state_idle", dut.state_q == IDLE, 1);
    reset = 1'b0;
    exp_q.delete();
    exp_done  = got_done;
    any_valid = 1'b0;
    any_done  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any_valid |= bus.row_valid;
      any_done  |= bus.quad_done;
    end
    check("abort_nothing_emitted", any_valid, 0);
    check("abort_no_done", any_done, 0);
    check("abort_ready_again", bus.quad_ready, 1);
    mon_en = 1'b1;
    issue_quad(sq);
    wait_done();
    check("after_abort_rows", rows_hs, 3);

    // Random quads with random downstream back-pressure.
    rand_ready = 1'b1;
    drawy_viol = 0;
    for (int k = 0; k < 30; k++) begin
      int x0, y0, w, h, d;
      x0 = int'($urandom_range(0, 330));
      y0 = int'($urandom_range(0, 495));
      w  = int'($urandom_range(0, 15));
      h  = int'($urandom_range(0, 10));
      d  = int'($urandom_range(0, 5));
      issue_quad(mk_quad(x0 + d, y0, x0, y0 + h, x0 + w, y0 + h, x0 + w + d, y0));
      wait_done();
    end
    rand_ready = 1'b0;
    check("random_drawY_in_range", drawy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quad_scan_sequencer.md
Name: quad_scan_sequencer

Overview:
- Drives the combinational quad edge-function rasterizer one scanline at a time.
- Accepts one quadrilateral (4 counter-clockwise vec2 vertices, 10-bit screen coords) over a valid/ready handshake and computes its Y bounding box, clipped to the screen.
- Presents vertices plus drawY to the rasterizer for each row, registers the returned per-pixel inside mask, and streams {y, mask} rows downstream to the line-buffer writer over valid/ready.
- Sits between the geometry/vertex source and the rasterizer/framebuffer path.

Parameters:
- warp_width, 320, pixels per rasterizer row; mask width.
- V_RES, 480, screen height; rows with y >= V_RES are never issued.
- SKIP_EMPTY, 1, when 1, rows whose mask is all zero are not emitted.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- quad_valid  in  1  quad offered.
- quad_ready  out  1  sequencer can accept a quad.
- quad_vertices  in  4x2x10  vertices[i][0]=x, [i][1]=y, counter-clockwise.
- rast_vertices  out  4x2x10  registered copy of the accepted quad, to the rasterizer.
- rast_drawY  out  10  current scanline, to the rasterizer.
- rast_isInside  in  warp_width  combinational mask from the rasterizer for rast_drawY.
- row_valid  out  1  row output valid.
- row_ready  in  1  downstream accepts the row.
- row_y  out  10  scanline of the emitted row.
- row_mask  out  warp_width  bit x = pixel x inside.
- row_last  out  1  final row of this quad.
- quad_done  out  1  one-cycle pulse when the quad is fully processed.

Behaviour:
- Reset values: quad_ready=0 in the reset cycle, then 1 in IDLE. row_valid=0, row_last=0, quad_done=0, row_y=0, row_mask=0, rast_drawY=0, rast_vertices=0. Reset mid-operation abandons the quad and any pending row; nothing is emitted afterwards.
- FSM states:
  - IDLE: quad_ready=1. quad_valid&quad_ready latches the vertices into rast_vertices -> SETUP.
  - SETUP (1 cycle): ymin = min of the 4 y values, ymax = max of the 4 y values (unsigned 10-bit). ymax_c = min(ymax, V_RES-1). If ymin > ymax_c, pulse quad_done and go to IDLE with no rows emitted. Otherwise rast_drawY <= ymin -> SCAN.
  - SCAN (1 cycle per row): rast_isInside is sampled in the same cycle rast_drawY is stable, because the rasterizer is combinational. Last = (rast_drawY == ymax_c).
    - If SKIP_EMPTY and the mask is zero: if not last, increment rast_drawY and stay; if last, pulse quad_done and go to IDLE. If every row is empty, no rows are emitted and row_last is never seen.
    - Otherwise load row_y, row_mask and row_last=last, assert row_valid -> EMIT.
  - EMIT: hold all row_* stable while row_valid && !row_ready.
    - On handshake: if row_last, pulse quad_done in that cycle and go to IDLE. Otherwise increment rast_drawY -> SCAN.
- Handshake rules:
  - row_valid never drops without a handshake.
  - quad_ready is 0 in every state except IDLE, so a new quad can be accepted no earlier than the cycle after quad_done.
- Throughput: a non-empty row takes 2 cycles (SCAN+EMIT) when row_ready is held high. An empty row takes 1 cycle with SKIP_EMPTY=1.
- Degenerate quads:
  - ymin == ymax: exactly 1 row is scanned.
  - Zero-area quad: rows are scanned normally, and the rasterizer's mask decides what is emitted.
- Arithmetic:
  - Unsigned 10-bit compares only. The y increment never wraps, because SCAN stops at ymax_c <= V_RES-1 < 1023.
  - row_last is registered, not combinational on ready.

Decomposition:
- Package quad_pkg holds:
  - typedef vec2_t (logic [9:0] [2]) and quad_t (vec2_t [4]);
  - constants COORD_W=10, V_RES_DEFAULT=480;
  - the state enum {IDLE, SETUP, SCAN, EMIT}.
- One natural sub-module, quad_ybounds: combinational min/max of 4 y values plus clip, producing ymin, ymax_c and empty. The FSM instantiates it.
- The bench instantiates the existing rasterizer alongside the sequencer.

Test Plan:
- Axis square (100,100),(100,102),(102,102),(102,100) entered counter-clockwise, row_ready=1 -> rows y=100,101,102 in order, each with the expected mask bits set, row_last only on y=102, quad_done one cycle after the y=102 handshake.
- Same quad with row_ready low for 5 cycles on y=101 -> row_y/row_mask/row_valid held stable, rast_drawY stays 101, no duplicate or skipped row.
- Quad with all y in 470..490, V_RES=480 -> last emitted row_y=479 with row_last=1, and no y >= 480 ever appears on rast_drawY.
- Quad with all y=500 -> SETUP finds it empty, quad_done pulses, zero rows are emitted, and quad_ready returns to 1.
- Thin quad whose rows 200..204 are empty except y=202, SKIP_EMPTY=1 -> exactly one row (y=202) is emitted; quad_done pulses after the y=204 scan, and row_last never asserts.
- Reset asserted in EMIT with row_valid=1 -> the next cycle shows row_valid=0, quad_done=0, the FSM in IDLE, and a fresh quad is accepted afterwards.
